csr_file: RTL and testbench

Machine-mode CSR file for the RV32 pipeline. It serves combinational CSR reads to the execute-side stage and returns per-access read/write masks to writeback for RVFI. It commits CSR writes and trap/mret state updates issued by writeback on the clock edge, and maintains the 64-bit cycle and instret counters. It is the storage end of the writeback CSR interface (address/wdata in, rmask/wmask out) and supplies mtvec/mepc for PC redirect.

---
 rtl/csr_file.sv | 201 ++++++++++++++++++++
 tb/tb_csr_file.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file -- machine-mode CSR file for the RV32 pipeline.
//
// Serves combinational CSR reads to the execute side, reports per-access
// read/write masks to writeback, and commits CSR writes plus trap/mret
// state updates on the rising clock edge.
//
// Optional feature macro: CSR_COUNTERS_EN
//   defined   -> mcycle/minstret (+h) and cycle/instret (+h) read-only aliases
//   undefined -> no counter registers; those addresses read as unimplemented
//
// Parameters:
//   MTVEC_RESET  reset value of mtvec (bits 1:0 forced to 0)
//   MHARTID      value returned by mhartid
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   rd_csr_addr_i/rdata_o  execute-side combinational read port
//   wb_csr_addr_i/we_i/wdata_i, wb_csr_rmask_o/wmask_o   writeback CSR access
//   wb_valid_i, wb_trap_*  retire / trap information from writeback
//   wb_mret_i              retiring instruction is mret
//   mtvec_o, mepc_o        registered trap vector / exception PC for redirect
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] rd_csr_addr_i,
  output logic [31:0] rd_csr_rdata_o,
  input  logic [11:0] wb_csr_addr_i,
  input  logic        wb_csr_we_i,
  input  logic [31:0] wb_csr_wdata_i,
  output logic [31:0] wb_csr_rmask_o,
  output logic [31:0] wb_csr_wmask_o,
  input  logic        wb_valid_i,
  input  logic        wb_trap_valid_i,
  input  logic [31:0] wb_trap_pc_i,
  input  logic [31:0] wb_trap_mcause_i,
  input  logic [31:0] wb_trap_mtval_i,
  input  logic        wb_mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  logic        r_mst_mie;   // mstatus.MIE
  logic        r_mst_mpie;  // mstatus.MPIE
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
`endif

  logic [31:0] w_mstatus;
  logic [32:0] w_rd;        // {implemented, value} for the read port
  logic [32:0] w_wb;        // {implemented, value} for the writeback address
  logic [31:0] w_wmask;     // writable bits of wb_csr_addr_i
  logic [31:0] w_new;       // merged write value
  logic        w_we;        // write commits this edge

  // MPP is hardwired to M-mode, so it always reads 2'b11.
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mst_mpie, 3'b0, r_mst_mie, 3'b0};

  function automatic logic [32:0] f_rd(input logic [11:0] a);
    logic [32:0] v;
    v = 33'b0;
    case (a)
      12'h300: v = {1'b1, w_mstatus};
      12'h301: v = {1'b1, MISA_VAL};
      12'h304: v = {1'b1, r_mie};
      12'h305: v = {1'b1, r_mtvec};
      12'h340: v = {1'b1, r_mscratch};
      12'h341: v = {1'b1, r_mepc};
      12'h342: v = {1'b1, r_mcause};
      12'h343: v = {1'b1, r_mtval};
      12'h344: v = {1'b1, 32'h0};
      12'hF14: v = {1'b1, MHARTID};
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: v = {1'b1, r_mcycle[31:0]};
      12'hB80, 12'hC80: v = {1'b1, r_mcycle[63:32]};
      12'hB02, 12'hC02: v = {1'b1, r_minstret[31:0]};
      12'hB82, 12'hC82: v = {1'b1, r_minstret[63:32]};
`endif
      default: v = 33'b0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] f_wmask(input logic [11:0] a);
    logic [31:0] m;
    m = 32'h0;
    case (a)
      12'h300: m = 32'h0000_0088;
      12'h304: m = 32'h0000_0888;
      12'h305, 12'h341: m = 32'hFFFF_FFFC;
      12'h340, 12'h342, 12'h343: m = 32'hFFFF_FFFF;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82: m = 32'hFFFF_FFFF;
`endif
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  always_comb begin
    w_rd    = f_rd(rd_csr_addr_i);
    w_wb    = f_rd(wb_csr_addr_i);
    w_wmask = f_wmask(wb_csr_addr_i);
  end

  assign rd_csr_rdata_o = w_rd[31:0];
  assign wb_csr_rmask_o = {32{w_wb[32]}};
  assign wb_csr_wmask_o = wb_csr_we_i ? w_wmask : 32'h0;
  assign w_new          = (w_wb[31:0] & ~w_wmask) | (wb_csr_wdata_i & w_wmask);
  // Address 0 and RO addresses decode to a zero mask, so they never commit.
  assign w_we           = wb_csr_we_i & ~wb_trap_valid_i & (|w_wmask);

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mst_mie  <= 1'b0;
      r_mst_mpie <= 1'b0;
      r_mie      <= 32'h0;
      r_mtvec    <= MTVEC_RESET & 32'hFFFF_FFFC;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
      r_mtval    <= 32'h0;
    end else if (wb_trap_valid_i) begin
      // Trap wins over both CSR write and mret.
      r_mepc     <= wb_trap_pc_i & 32'hFFFF_FFFC;
      r_mcause   <= wb_trap_mcause_i;
      r_mtval    <= wb_trap_mtval_i;
      r_mst_mpie <= r_mst_mie;
      r_mst_mie  <= 1'b0;
    end else begin
      if (w_we) begin
        case (wb_csr_addr_i)
          12'h300: begin
            r_mst_mie  <= w_new[3];
            r_mst_mpie <= w_new[7];
          end
          12'h304: r_mie      <= w_new;
          12'h305: r_mtvec    <= w_new;
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= w_new;
          12'h342: r_mcause   <= w_new;
          12'h343: r_mtval    <= w_new;
          default: ;
        endcase
      end
      // mret is issued after the write so it owns mstatus if both hit.
      if (wb_mret_i) begin
        r_mst_mie  <= r_mst_mpie;
        r_mst_mpie <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] w_cyc_inc;
  logic [63:0] w_ins_inc;
  logic        w_ins_en;

  assign w_ins_en  = wb_valid_i & ~wb_trap_valid_i;
  assign w_cyc_inc = r_mcycle + 64'd1;
  assign w_ins_inc = r_minstret + {63'b0, w_ins_en};

  // Low-half write holds the high half; high-half write keeps the low
  // increment but drops its carry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mcycle   <= 64'h0;
      r_minstret <= 64'h0;
    end else begin
      if (w_we && wb_csr_addr_i == 12'hB00)
        r_mcycle <= {r_mcycle[63:32], wb_csr_wdata_i};
      else if (w_we && wb_csr_addr_i == 12'hB80)
        r_mcycle <= {wb_csr_wdata_i, w_cyc_inc[31:0]};
      else
        r_mcycle <= w_cyc_inc;

      if (w_we && wb_csr_addr_i == 12'hB02)
        r_minstret <= {r_minstret[63:32], wb_csr_wdata_i};
      else if (w_we && wb_csr_addr_i == 12'hB82)
        r_minstret <= {wb_csr_wdata_i, w_ins_inc[31:0]};
      else
        r_minstret <= w_ins_inc;
    end
  end
`endif

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file -- directed self-checking bench for csr_file.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_csr_file;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] rd_csr_addr_i;
  logic [31:0] rd_csr_rdata_o;
  logic [11:0] wb_csr_addr_i;
  logic        wb_csr_we_i;
  logic [31:0] wb_csr_wdata_i;
  logic [31:0] wb_csr_rmask_o;
  logic [31:0] wb_csr_wmask_o;
  logic        wb_valid_i;
  logic        wb_trap_valid_i;
  logic [31:0] wb_trap_pc_i;
  logic [31:0] wb_trap_mcause_i;
  logic [31:0] wb_trap_mtval_i;
  logic        wb_mret_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;

  int n_chk  = 0;
  int n_pass = 0;

  csr_file #(.MTVEC_RESET(32'h0000_1003), .MHARTID(32'h0000_0007)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_csr_addr_i(rd_csr_addr_i), .rd_csr_rdata_o(rd_csr_rdata_o),
    .wb_csr_addr_i(wb_csr_addr_i), .wb_csr_we_i(wb_csr_we_i),
    .wb_csr_wdata_i(wb_csr_wdata_i), .wb_csr_rmask_o(wb_csr_rmask_o),
    .wb_csr_wmask_o(wb_csr_wmask_o), .wb_valid_i(wb_valid_i),
    .wb_trap_valid_i(wb_trap_valid_i), .wb_trap_pc_i(wb_trap_pc_i),
    .wb_trap_mcause_i(wb_trap_mcause_i), .wb_trap_mtval_i(wb_trap_mtval_i),
    .wb_mret_i(wb_mret_i), .mtvec_o(mtvec_o), .mepc_o(mepc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one writeback access (no trap/mret/retire) and settle.
  task automatic wb(input logic [11:0] a, input logic we, input logic [31:0] d);
    wb_csr_addr_i  = a;
    wb_csr_we_i    = we;
    wb_csr_wdata_i = d;
    #1;
  endtask

  task automatic idle();
    wb_csr_addr_i = 12'h0; wb_csr_we_i = 1'b0; wb_csr_wdata_i = 32'h0;
    wb_valid_i = 1'b0; wb_trap_valid_i = 1'b0; wb_mret_i = 1'b0;
  endtask

  // Read through the execute-side port.
  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    rd_csr_addr_i = a;
    #1;
    chk(tag, rd_csr_rdata_o, exp);
  endtask

  initial begin
    rst_i = 1'b1;
    rd_csr_addr_i = 12'h0;
    wb_trap_pc_i = 32'h0; wb_trap_mcause_i = 32'h0; wb_trap_mtval_i = 32'h0;
    idle();
    tick(); tick();
    // Reset state
    chk("rst_mtvec_o", mtvec_o, 32'h0000_1000);
    chk("rst_mepc_o", mepc_o, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rst_i = 1'b0;
    rd("rst_mtvec", 12'h305, 32'h0000_1000);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("mhartid", 12'hF14, 32'h0000_0007);
`ifdef CSR_COUNTERS_EN
    rd("rst_mcycle", 12'hB00, 32'h0);
    tick();
    rd("mcycle_1", 12'hB00, 32'h1);
`else
    tick();
`endif

    // mtvec write with low bits masked off
    wb(12'h305, 1'b1, 32'h8000_0003);
    chk("mtvec_wmask", wb_csr_wmask_o, 32'hFFFF_FFFC);
    chk("mtvec_rmask", wb_csr_rmask_o, 32'hFFFF_FFFF);
    rd("mtvec_nobypass", 12'h305, 32'h0000_1000);
    tick(); idle();
    chk("mtvec_o_wr", mtvec_o, 32'h8000_0000);

    // mstatus: only MIE/MPIE writable, MPP stays 11
    wb(12'h300, 1'b1, 32'h0000_0008);
    chk("mstatus_wmask", wb_csr_wmask_o, 32'h0000_0088);
    tick(); idle();
    rd("mstatus_mie1", 12'h300, 32'h0000_1808);
    wb(12'h340, 1'b1, 32'h1234_5678);
    tick(); idle();
    rd("mscratch", 12'h340, 32'h1234_5678);

    // Trap with a simultaneous mscratch write that must be suppressed
    wb_trap_valid_i = 1'b1; wb_valid_i = 1'b1;
    wb_trap_pc_i = 32'h0000_0102; wb_trap_mcause_i = 32'h2; wb_trap_mtval_i = 32'h0000_DEAD;
    wb(12'h340, 1'b1, 32'hFFFF_FFFF);
    tick(); idle();
    chk("trap_mepc_o", mepc_o, 32'h0000_0100);
    rd("trap_mcause", 12'h342, 32'h2);
    rd("trap_mtval", 12'h343, 32'h0000_DEAD);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    rd("trap_mscratch", 12'h340, 32'h1234_5678);

    // mret restores MIE from MPIE
    wb_mret_i = 1'b1; wb_valid_i = 1'b1; #1;
    tick(); idle();
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    // Trap and mret together: trap wins
    wb_trap_valid_i = 1'b1; wb_mret_i = 1'b1; wb_trap_pc_i = 32'h0000_0203; #1;
    tick(); idle();
    rd("trapmret_mstatus", 12'h300, 32'h0000_1880);
    chk("trapmret_mepc_o", mepc_o, 32'h0000_0200);

    // mie writable bits, mip RO 0
    wb(12'h304, 1'b1, 32'hFFFF_FFFF);
    chk("mie_wmask", wb_csr_wmask_o, 32'h0000_0888);
    tick(); idle();
    rd("mie", 12'h304, 32'h0000_0888);
    wb(12'h344, 1'b1, 32'hFFFF_FFFF);
    chk("mip_wmask", wb_csr_wmask_o, 32'h0);
    chk("mip_rmask", wb_csr_rmask_o, 32'hFFFF_FFFF);
    tick(); idle();
    rd("mip", 12'h344, 32'h0);

    // Unimplemented / RO / address 0
    wb(12'h123, 1'b1, 32'hFFFF_FFFF);
    chk("unimp_rmask", wb_csr_rmask_o, 32'h0);
    chk("unimp_wmask", wb_csr_wmask_o, 32'h0);
    rd("unimp_rdata", 12'h123, 32'h0);
    wb(12'h301, 1'b1, 32'h0);
    chk("misa_wmask", wb_csr_wmask_o, 32'h0);
    tick(); idle();
    rd("misa_kept", 12'h301, 32'h4000_0100);
    wb(12'h000, 1'b1, 32'hFFFF_FFFF);
    chk("addr0_rmask", wb_csr_rmask_o, 32'h0);
    chk("addr0_wmask", wb_csr_wmask_o, 32'h0);
    idle();

`ifdef CSR_COUNTERS_EN
    // mcycle preload then carry into high half
    wb(12'hB80, 1'b1, 32'h5); tick();
    wb(12'hB00, 1'b1, 32'hFFFF_FFFF); tick(); idle();
    rd("mcyc_lo_pre", 12'hB00, 32'hFFFF_FFFF);
    rd("mcyc_hi_pre", 12'hB80, 32'h5);
    tick();
    rd("mcyc_lo_wrap", 12'hB00, 32'h0);
    rd("mcyc_hi_carry", 12'hB80, 32'h6);
    rd("cycleh_alias", 12'hC80, 32'h6);
    // mcycleh write in the wrap cycle discards the carry
    wb(12'hB00, 1'b1, 32'hFFFF_FFFF); tick();
    wb(12'hB80, 1'b1, 32'h0); tick(); idle();
    rd("mcycleh_wr_wrap", 12'hB80, 32'h0);
    rd("mcycle_wr_wrap_lo", 12'hB00, 32'h0);
    // 64-bit wrap to zero
    wb(12'hB80, 1'b1, 32'hFFFF_FFFF); tick();
    wb(12'hB00, 1'b1, 32'hFFFF_FFFF); tick(); idle();
    tick();
    rd("mcyc64_wrap_lo", 12'hB00, 32'h0);
    rd("mcyc64_wrap_hi", 12'hB80, 32'h0);

    // minstret: 3 retires, one traps -> +2
    wb(12'hB82, 1'b1, 32'h0); tick();
    wb(12'hB02, 1'b1, 32'h0); tick(); idle();
    wb_valid_i = 1'b1; tick();
    wb_trap_valid_i = 1'b1; tick();
    wb_trap_valid_i = 1'b0; tick(); idle();
    rd("minstret_2", 12'hB02, 32'h2);
    rd("instret_alias", 12'hC02, 32'h2);
    wb(12'hC02, 1'b1, 32'hFFFF_FFFF);
    chk("instret_ro_wmask", wb_csr_wmask_o, 32'h0);
    chk("instret_rmask", wb_csr_rmask_o, 32'hFFFF_FFFF);
    tick(); idle();
    rd("instret_ro_kept", 12'hC02, 32'h2);
    wb(12'hB02, 1'b1, 32'hFFFF_FFFF); tick(); idle();
    wb_valid_i = 1'b1; tick(); idle();
    rd("minstret_carry_lo", 12'hB02, 32'h0);
    rd("minstret_carry_hi", 12'hC82, 32'h1);
`else
    rd("nocnt_b00", 12'hB00, 32'h0);
    rd("nocnt_c00", 12'hC00, 32'h0);
    wb(12'hB00, 1'b1, 32'hFFFF_FFFF);
    chk("nocnt_b00_rmask", wb_csr_rmask_o, 32'h0);
    chk("nocnt_b00_wmask", wb_csr_wmask_o, 32'h0);
    wb(12'hC00, 1'b0, 32'h0);
    chk("nocnt_c00_rmask", wb_csr_rmask_o, 32'h0);
    idle();
`endif

    // Asynchronous reset mid-operation discards the pending write
    wb(12'h340, 1'b1, 32'hAAAA_AAAA);
    rst_i = 1'b1; #1;
    chk("arst_mtvec_o", mtvec_o, 32'h0000_1000);
    chk("arst_mepc_o", mepc_o, 32'h0);
    rd("arst_mscratch", 12'h340, 32'h0);
    tick(); idle();
    rd("arst_mscratch_held", 12'h340, 32'h0);
    rd("arst_mie", 12'h304, 32'h0);
    rst_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
